cpu_seq: RTL and testbench
==========================

# cpu_seq

Multi-cycle sequencer for the single-issue CPU datapath: owns the program counter and instruction register, fetches instructions over a request/acknowledge port, presents each instruction to the combinational decoder, and gates the decoder's register-file write enable into a single write-back cycle. Sits between instruction memory and the decoder/ALU/register file; it is the only source of the PC and of the committed write enable.

## Interface
- PC_WIDTH, 10, width of byte-addressed PC and instruction address
- RESET_PC, 0, PC value loaded on reset (multiple of 4)

- clk  input  1  core clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- run  input  1  start/continue execution; sampled in IDLE and at end of WB
- imem_req  output  1  instruction fetch request
- imem_addr  output  PC_WIDTH  fetch address, equals pc
- imem_ack  input  1  fetch data valid this cycle
- imem_rdata  input  32  instruction word, valid when imem_ack high
- instr  output  32  instruction register, drives decoder
- dec_rf_we  input  1  decoder's raw register-file write enable
- rf_we  output  1  committed register-file write enable
- pc  output  PC_WIDTH  current PC
- instret  output  32  retired instruction counter
- halted  output  1  sequencer in HALT
- illegal  output  1  halt caused by unsupported opcode

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: run=1 → FETCH next cycle; else stay.
- FETCH: imem_req=1, imem_addr=pc held stable; on imem_ack=1 load instr←imem_rdata, → DECODE. imem_ack outside FETCH ignored.
- DECODE: classify instr[6:0]. instr==32'h00100073 (EBREAK) → HALT, illegal=0, no retire. opcode 7'b0010011 → EXEC. Any other opcode → illegal path (see Configuration).
- EXEC: one cycle for ALU settle; → WB.
- WB: rf_we=dec_rf_we for this cycle only; pc←pc+4 (mod 2^PC_WIDTH, wraps silently); instret←instret+1 (wraps at 2^32); then run=1 → FETCH, run=0 → IDLE.
- HALT: imem_req=0, rf_we=0, halted=1; exit only by reset.
- run deasserted mid-instruction: current instruction completes through WB, then IDLE.

## Timing
- Reset values: state IDLE, imem_req 0, imem_addr/pc RESET_PC, instr 0, rf_we 0, instret 0, halted 0, illegal 0.
- Reset is asynchronous; assertion mid-FETCH drops imem_req immediately; no partial retire.
- Minimum instruction latency 4 cycles (FETCH with same-cycle ack, DECODE, EXEC, WB); each FETCH wait cycle adds 1.
- Back-to-back with run=1 and zero-wait memory: one retire per 4 cycles; imem_req low during DECODE/EXEC/WB.
- rf_we is registered-state-gated: never high outside WB, at most one cycle per instruction.
- pc, instret update on the clock edge leaving WB; halted/illegal rise on the edge entering HALT.

## Configuration
- CPU_SEQ_ILLEGAL_HALT_EN defined: unsupported opcode in DECODE → HALT with illegal=1, no retire, pc unchanged (points at faulting instruction).
- Not defined: unsupported opcode treated as NOP: DECODE → EXEC → WB with rf_we forced 0, pc+=4, instret+=1; illegal tied 0.

## Test plan
- Reset, run=1, zero-wait memory returning 32'h00500093 (addi x1,x0,5) with dec_rf_we=1 → imem_req cycle 1, rf_we high exactly in cycle 4, pc 0→4, instret 1.
- imem_ack delayed 3 cycles at pc=8 → imem_req and imem_addr=8 held 4 cycles, instr updated only on ack cycle, retire 3 cycles later.
- Fetch 32'h00100073 → halted=1, illegal=0, pc and instret unchanged, no further imem_req.
- Fetch 32'h00000033 with macro defined → halted=1, illegal=1, pc unchanged; without macro → rf_we stays 0, pc+=4, instret+=1, execution continues.
- PC_WIDTH=4, RESET_PC=12, run=1 → after retire pc wraps to 0, fetch address 0.
- run dropped during EXEC → WB completes (instret+1), state returns to IDLE, imem_req stays 0; rst_n pulsed mid-FETCH → imem_req 0 same cycle, all outputs at reset values.

Source files
------------

// File: rtl/cpu_seq.sv
// cpu_seq: multi-cycle fetch/decode/exec/writeback sequencer; define CPU_SEQ_ILLEGAL_HALT_EN to halt on unsupported opcodes
module cpu_seq #(
  parameter int PC_WIDTH = 10,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instr,
  input  logic                dec_rf_we,
  output logic                rf_we,
  output logic [PC_WIDTH-1:0] pc,
  output logic [31:0]         instret,
  output logic                halted,
  output logic                illegal
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;
`ifdef CPU_SEQ_ILLEGAL_HALT_EN
  localparam state_t BAD_NX = HALT;
`else
  localparam state_t BAD_NX = EXEC;
`endif
  state_t state, state_nx;
  logic nop, is_ebreak, bad_op;
  assign is_ebreak = instr == 32'h00100073;
  assign bad_op = instr[6:0] != 7'b0010011;
  assign imem_req = state == FETCH;
  assign imem_addr = pc;
  assign halted = state == HALT;
  assign rf_we = state == WB && dec_rf_we && !nop;
  // next-state selection; run is only consulted in IDLE and when leaving WB
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = run ? FETCH : IDLE;
      FETCH:   state_nx = imem_ack ? DECODE : FETCH;
      DECODE:  state_nx = is_ebreak ? HALT : bad_op ? BAD_NX : EXEC;
      EXEC:    state_nx = WB;
      WB:      state_nx = run ? FETCH : IDLE;
      default: state_nx = HALT;
    endcase
  end
  // state, instruction register, pc/instret commit and the halt cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= PC_WIDTH'(RESET_PC);
      instr   <= '0;
      instret <= '0;
      nop     <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == FETCH && imem_ack) instr <= imem_rdata;
      if (state == DECODE) nop <= bad_op;
      if (state == DECODE && state_nx == HALT) illegal <= !is_ebreak;
      if (state == WB) begin
        pc      <= pc + PC_WIDTH'(4);
        instret <= instret + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: scoreboard bench for cpu_seq covering fetch timing, wait states, halt, illegal opcode, pc wrap, run drop and async reset
module tb_cpu_seq;
  logic clk = 1'b0;
  logic rst_n, run, imem_req, imem_ack, rf_we, halted, illegal, dec_rf_we;
  logic [9:0] imem_addr, pc;
  logic [31:0] imem_rdata, instr, instret;
  logic run_w, req_w, ack_w, rf_we_w, halted_w, illegal_w;
  logic [3:0] addr_w, pc_w;
  logic [31:0] rdata_w, instr_w, instret_w;
  logic [31:0] mem [0:7];
  int n_cmp = 0, n_err = 0, wcnt = 0;

  typedef struct {
    bit        is_halt;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic      flag;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  cpu_seq dut (
    .clk(clk), .rst_n(rst_n), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .dec_rf_we(dec_rf_we),
    .rf_we(rf_we), .pc(pc), .instret(instret), .halted(halted), .illegal(illegal)
  );

  cpu_seq #(.PC_WIDTH(4), .RESET_PC(12)) dut_w (
    .clk(clk), .rst_n(rst_n), .run(run_w), .imem_req(req_w), .imem_addr(addr_w),
    .imem_ack(ack_w), .imem_rdata(rdata_w), .instr(instr_w), .dec_rf_we(1'b1),
    .rf_we(rf_we_w), .pc(pc_w), .instret(instret_w), .halted(halted_w), .illegal(illegal_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input bit h, input logic [31:0] p, input logic [31:0] c, input logic f);
    exp_t e;
    e.is_halt = h; e.pc = p; e.cnt = c; e.flag = f;
    sb.push_back(e);
  endtask

  // instruction memory for dut: zero wait except 3 extra cycles at address 8
  initial begin
    mem[0] = 32'h00500093; mem[1] = 32'h00a00113; mem[2] = 32'h00300193; mem[3] = 32'h00000033;
    mem[4] = 32'h00100073; mem[5] = 32'h00100073; mem[6] = 32'h00100073; mem[7] = 32'h00100073;
    imem_ack = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (imem_req && wcnt == ((imem_addr == 10'd8) ? 3 : 0)) begin
        imem_ack = 1'b1; imem_rdata = mem[imem_addr[4:2]]; wcnt = 0;
      end else begin
        imem_ack = 1'b0; wcnt = imem_req ? wcnt + 1 : 0;
      end
    end
  end

  // zero-wait memory for the narrow-pc instance
  initial begin
    ack_w = 1'b0; rdata_w = 32'h00500093;
    forever begin
      @(negedge clk);
      ack_w = req_w;
    end
  end

  // monitor: compare each retire (instret step) and each halt entry against the scoreboard
  initial begin
    logic [31:0] prev_cnt;
    logic prev_rf, prev_h;
    exp_t e;
    prev_cnt = '0; prev_rf = 1'b0; prev_h = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && instret == prev_cnt + 32'd1) begin
        if (sb.size() == 0) chk("unexpected_retire", instret, prev_cnt);
        else begin
          e = sb.pop_front();
          chk("retire_kind", 32'(e.is_halt), 32'd0);
          chk("retire_pc", 32'(pc), e.pc);
          chk("retire_instret", instret, e.cnt);
          chk("retire_rf_we", 32'(prev_rf), 32'(e.flag));
        end
      end
      if (rst_n && halted && !prev_h) begin
        if (sb.size() == 0) chk("unexpected_halt", 32'(halted), 32'd0);
        else begin
          e = sb.pop_front();
          chk("halt_kind", 32'(e.is_halt), 32'd1);
          chk("halt_pc", 32'(pc), e.pc);
          chk("halt_instret", instret, e.cnt);
          chk("halt_illegal", 32'(illegal), 32'(e.flag));
        end
      end
      prev_cnt = instret; prev_rf = rf_we; prev_h = halted;
    end
  end

  initial begin
    bit req_e, rf_e;
    rst_n = 1'b0; run = 1'b0; run_w = 1'b0; dec_rf_we = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_pc_w", 32'(pc_w), 32'd12);
    push(0, 4, 1, 1); push(0, 8, 2, 1); push(0, 12, 3, 1);
`ifdef CPU_SEQ_ILLEGAL_HALT_EN
    push(1, 12, 3, 1);
`else
    push(0, 16, 4, 0); push(1, 16, 4, 0);
`endif
    rst_n = 1'b1; run = 1'b1; run_w = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      req_e = c == 1 || c == 5 || (c >= 9 && c <= 12) || c == 16;
      rf_e = c == 4 || c == 8 || c == 15;
      chk($sformatf("req_c%0d", c), 32'(imem_req), 32'(req_e));
      chk($sformatf("rf_we_c%0d", c), 32'(rf_we), 32'(rf_e));
      if (req_e) chk($sformatf("addr_c%0d", c), 32'(imem_addr), c < 5 ? 32'd0 : c < 9 ? 32'd4 : c < 16 ? 32'd8 : 32'd12);
      if (c >= 9 && c <= 12) chk($sformatf("instr_hold_c%0d", c), instr, 32'h00a00113);
      if (c == 13) chk("instr_load", instr, 32'h00300193);
      if (c == 5) begin
        chk("wrap_pc", 32'(pc_w), 32'd0);
        chk("wrap_addr", 32'(addr_w), 32'd0);
        chk("wrap_req", 32'(req_w), 32'd1);
        chk("wrap_instret", instret_w, 32'd1);
        run_w = 1'b0;
      end
    end
    for (int i = 0; i < 20 && !halted; i++) step();
    chk("halt_reached", 32'(halted), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_no_req", 32'(imem_req), 32'd0);
      chk("halt_no_rf_we", 32'(rf_we), 32'd0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    push(0, 4, 1, 1);
    rst_n = 1'b1; run = 1'b1;
    step();
    step();
    step();
    run = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      step();
      if (c >= 5) chk($sformatf("idle_req_c%0d", c), 32'(imem_req), 32'd0);
    end
    chk("drop_instret", instret, 32'd1);
    chk("drop_pc", 32'(pc), 32'd4);
    run = 1'b1;
    step();
    chk("refetch_req", 32'(imem_req), 32'd1);
    chk("refetch_addr", 32'(imem_addr), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("async_req", 32'(imem_req), 32'd0);
    chk("async_pc", 32'(pc), 32'd0);
    chk("async_instr", instr, 32'd0);
    chk("async_instret", instret, 32'd0);
    chk("async_rf_we", 32'(rf_we), 32'd0);
    chk("async_halted", 32'(halted), 32'd0);
    chk("async_illegal", 32'(illegal), 32'd0);
    step();
    step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
